// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: FSM state encodings and Gray/binary conversions.
// Both conversion functions work on a 32-bit container; narrower pointers are
// zero-extended on the way in and truncated on the way out, so one function serves every width.
package fifo_pkg;

   // Read/write FSM states; RD_DATA doubles as the "data valid" indication.
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } fifo_state_t;

   localparam int PTR_MAX_W = 32;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits in the Gray code stay zero in the binary result, so
   // truncating back to the pointer width is exact.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// Latency: 2 clk edges. No flow control: samples every edge.
// Ports: clk, rst_n (async active-low), d (foreign-domain input), q (synchronized output).
module sync_2ff #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rd_fsm.sv
// Read-side controller of the async FIFO: read pointer, write-pointer synchronizer,
// empty/level flags, pop-on-empty error pulse and a read-data-valid FSM.
// Latency: rd_en same cycle as an accepted pop, rd_valid one cycle later; write pointer
// seen by empty/level on the 3rd read edge. Backpressure: pops are refused while empty_fsm is set.
// Ports: rd_clk_fsm/rst_n_in_rd_fsm clock and async reset; pop_fsm consumer request;
// wt_ptr_gray_fsm unsynchronized write pointer; rd_en_fsm/rd_addr_fsm memory read port;
// rd_ptr_gray_fsm pointer to write domain; empty_fsm, rd_level_fsm status;
// rd_valid_fsm read data valid; pop_on_empty_error_fsm error pulse.
module rd_fsm
   import fifo_pkg::*;
#(
   parameter int   ADDR_WIDTH = 4,
   parameter logic s0         = 1'b0,
   parameter logic s1         = 1'b1
) (
   input  logic                  rd_clk_fsm,
   input  logic                  rst_n_in_rd_fsm,
   input  logic                  pop_fsm,
   input  logic [ADDR_WIDTH:0]   wt_ptr_gray_fsm,
   output logic                  rd_en_fsm,
   output logic [ADDR_WIDTH-1:0] rd_addr_fsm,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray_fsm,
   output logic                  empty_fsm,
   output logic [ADDR_WIDTH:0]   rd_level_fsm,
   output logic                  rd_valid_fsm,
   output logic                  pop_on_empty_error_fsm
);

   localparam int PW = ADDR_WIDTH + 1;

   localparam fifo_state_t ST_IDLE = fifo_state_t'(s0);
   localparam fifo_state_t ST_DATA = fifo_state_t'(s1);

   logic [PW-1:0] wq2_gray;
   logic [PW-1:0] wq2_bin;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] rd_bin_next;
   logic [PW-1:0] rd_gray_next;
   logic          pop_ok;

   fifo_state_t   ps;
   fifo_state_t   ns;

   sync_2ff #(
      .WIDTH (PW)
   ) u_wptr_sync (
      .clk   (rd_clk_fsm),
      .rst_n (rst_n_in_rd_fsm),
      .d     (wt_ptr_gray_fsm),
      .q     (wq2_gray)
   );

   assign wq2_bin = PW'(gray2bin(PTR_MAX_W'(wq2_gray)));

   // Refusal uses the registered flag: a write landing this cycle is not yet
   // visible, which is pessimistic but can never underflow.
   assign pop_ok    = pop_fsm & ~empty_fsm;
   assign rd_en_fsm = pop_ok;

   assign rd_bin_next  = rd_bin + PW'(pop_ok);
   assign rd_gray_next = PW'(bin2gray(PTR_MAX_W'(rd_bin_next)));

   assign rd_addr_fsm = rd_bin[ADDR_WIDTH-1:0];

   // Empty and level are computed from the next pointer so the pop that drains
   // the last entry raises empty at the same edge it retires.
   always_ff @(posedge rd_clk_fsm or negedge rst_n_in_rd_fsm) begin
      if (!rst_n_in_rd_fsm) begin
         rd_bin                 <= '0;
         rd_ptr_gray_fsm        <= '0;
         empty_fsm              <= 1'b1;
         rd_level_fsm           <= '0;
         pop_on_empty_error_fsm <= 1'b0;
      end else begin
         rd_bin                 <= rd_bin_next;
         rd_ptr_gray_fsm        <= rd_gray_next;
         empty_fsm              <= (rd_gray_next == wq2_gray);
         rd_level_fsm           <= wq2_bin - rd_bin_next;
         pop_on_empty_error_fsm <= pop_fsm & empty_fsm;
      end
   end

   always_ff @(posedge rd_clk_fsm or negedge rst_n_in_rd_fsm) begin
      if (!rst_n_in_rd_fsm) begin
         ps <= ST_IDLE;
      end else begin
         ps <= ns;
      end
   end

   always_comb begin
      ns = ps;
      case (ps)
         ST_IDLE: ns = pop_ok ? ST_DATA : ST_IDLE;
         ST_DATA: ns = pop_ok ? ST_DATA : ST_IDLE;
         default: ns = ST_IDLE;
      endcase
   end

   assign rd_valid_fsm = (ps == ST_DATA);

endmodule

// File: tb/tb_rd_fsm.sv
module tb_rd_fsm;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int PMOD  = 32;

   logic          rd_clk;
   logic          rst_n;
   logic          pop_fsm;
   logic [AW:0]   wt_ptr_gray_fsm;
   logic          rd_en_fsm;
   logic [AW-1:0] rd_addr_fsm;
   logic [AW:0]   rd_ptr_gray_fsm;
   logic          empty_fsm;
   logic [AW:0]   rd_level_fsm;
   logic          rd_valid_fsm;
   logic          err_fsm;

   rd_fsm #(.ADDR_WIDTH(AW), .s0(1'b0), .s1(1'b1)) dut (
      .rd_clk_fsm             (rd_clk),
      .rst_n_in_rd_fsm        (rst_n),
      .pop_fsm                (pop_fsm),
      .wt_ptr_gray_fsm        (wt_ptr_gray_fsm),
      .rd_en_fsm              (rd_en_fsm),
      .rd_addr_fsm            (rd_addr_fsm),
      .rd_ptr_gray_fsm        (rd_ptr_gray_fsm),
      .empty_fsm              (empty_fsm),
      .rd_level_fsm           (rd_level_fsm),
      .rd_valid_fsm           (rd_valid_fsm),
      .pop_on_empty_error_fsm (err_fsm)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   typedef struct {
      bit empty;
      int level;
      int gray;
      bit valid;
      bit err;
      bit en;
   } exp_t;

   exp_t exp_q[$];
   int   addr_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Reference model in plain counts: total writes issued, total reads retired,
   // and the write count as it stood one and two edges back.
   int  w_cnt, rd_m, wd1, wd2, level_m;
   bit  empty_m, valid_m, err_m;

   function automatic int gray_of(input int n);
      int m;
      m = n % PMOD;
      return m ^ (m >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      w_cnt = 0; rd_m = 0; wd1 = 0; wd2 = 0;
      level_m = 0; empty_m = 1'b1; valid_m = 1'b0; err_m = 1'b0;
   endfunction

   // One read-clock edge: a pop is taken only if the FIFO looked non-empty before
   // the edge; the read side then sees the write count from two edges earlier.
   function automatic void model_step(input bit p);
      bit acc;
      int vis;
      acc     = p && !empty_m;
      err_m   = p && empty_m;
      valid_m = acc;
      if (acc) rd_m++;
      vis     = wd2;
      wd2     = wd1;
      wd1     = w_cnt;
      level_m = vis - rd_m;
      empty_m = (level_m == 0);
   endfunction

   task automatic cycle(input bit p, input bit wr);
      exp_t e;
      @(posedge rd_clk); #1;
      if (wr && (w_cnt - rd_m) < DEPTH) w_cnt++;
      pop_fsm         = p;
      wt_ptr_gray_fsm = (AW+1)'(gray_of(w_cnt));
      e.empty = empty_m;
      e.level = level_m;
      e.gray  = gray_of(rd_m);
      e.valid = valid_m;
      e.err   = err_m;
      e.en    = p && !empty_m;
      exp_q.push_back(e);
      if (e.en) addr_q.push_back(rd_m % DEPTH);
      model_step(p);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_empty"}, int'(empty_fsm), 1);
      chk({tag, "_level"}, int'(rd_level_fsm), 0);
      chk({tag, "_valid"}, int'(rd_valid_fsm), 0);
      chk({tag, "_gray"},  int'(rd_ptr_gray_fsm), 0);
      chk({tag, "_addr"},  int'(rd_addr_fsm), 0);
      chk({tag, "_err"},   int'(err_fsm), 0);
      chk({tag, "_en"},    int'(rd_en_fsm), 0);
   endtask

   // Assert reset mid-cycle (away from any edge), check outputs react at once,
   // hold for two edges, then release with the write pointer at zero.
   task automatic do_reset(input string tag);
      @(posedge rd_clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      pop_fsm         = 1'b0;
      wt_ptr_gray_fsm = '0;
      repeat (2) @(posedge rd_clk);
      #1;
      rst_n = 1'b1;
      addr_q.delete();
      model_reset();
      model_step(1'b0);
   endtask

   // Monitor: compares every cycle that has a pushed expectation, and matches each
   // observed memory read against the address queued when the pop was issued.
   initial begin
      exp_t e;
      forever begin
         @(negedge rd_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("empty", int'(empty_fsm), int'(e.empty));
            chk("level", int'(rd_level_fsm), e.level);
            chk("rd_gray", int'(rd_ptr_gray_fsm), e.gray);
            chk("rd_valid", int'(rd_valid_fsm), int'(e.valid));
            chk("pop_err", int'(err_fsm), int'(e.err));
            chk("rd_en", int'(rd_en_fsm), int'(e.en));
         end
         if (rd_en_fsm === 1'b1) begin
            if (addr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rd_addr: read at addr %0d with no read expected", rd_addr_fsm);
            end else begin
               chk("rd_addr", int'(rd_addr_fsm), addr_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      pop_fsm         = 1'b0;
      wt_ptr_gray_fsm = '0;
      model_reset();
      repeat (2) @(posedge rd_clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      model_step(1'b0);

      // Sync latency: write pointer jumps 0 -> 2 entries, then pop held high.
      cycle(1'b0, 1'b0);
      w_cnt = 2;
      repeat (4) cycle(1'b0, 1'b0);
      repeat (4) cycle(1'b1, 1'b0);

      // Pop on empty for three cycles.
      repeat (3) cycle(1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0);

      // Full drain of 16 entries from a fresh pointer.
      do_reset("rst_a");
      w_cnt = DEPTH;
      repeat (3) cycle(1'b0, 1'b0);
      repeat (DEPTH) cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b1, 1'b0);

      // Reset in the middle of a drain at level 9, released with write pointer 0.
      do_reset("rst_b");
      w_cnt = DEPTH;
      repeat (3) cycle(1'b0, 1'b0);
      for (int i = 0; i < 40 && level_m > 9; i++) cycle(1'b1, 1'b0);
      do_reset("rst_mid");
      repeat (5) cycle(1'b0, 1'b0);
      repeat (2) cycle(1'b1, 1'b0);

      // Wrap-around: incremental writes and random pops until 40+ reads retire.
      for (int i = 0; i < 3000 && rd_m < 40; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (rd_m < 40) begin
         miscompares++;
         $display("FAIL wrap_budget: only %0d reads retired, need 40", rd_m);
      end

      // Random traffic with bursts of writes and reads at varying densities.
      for (int i = 0; i < 600; i++) begin
         int wr_bias;
         int pop_bias;
         wr_bias  = (i / 100) % 3;
         pop_bias = ((i / 100) + 1) % 3;
         cycle($urandom_range(0, 2) <= pop_bias, $urandom_range(0, 2) <= wr_bias);
      end
      repeat (25) cycle(1'b1, 1'b0);

      @(negedge rd_clk);
      @(negedge rd_clk);
      chk("addr_queue_drained", addr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
